// File: rtl/fcpu_io_axi_slave.sv
// AXI4 responder for the fcpu io port: byte writes feed the serial tx stream, reads
// return an rx byte or a status byte. Independent write and read FSMs.
module fcpu_io_axi_slave #(
    parameter int ID_W     = 4,
    parameter int DATA_W   = 8,
    parameter int STAT_BIT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ID_W-1:0]   io_awid,
    input  logic [31:0]       io_awaddr,
    input  logic [7:0]        io_awlen,
    input  logic              io_awvalid,
    output logic              io_awready,
    input  logic [DATA_W-1:0] io_wdata,
    input  logic              io_wstrb,
    input  logic              io_wlast,
    input  logic              io_wvalid,
    output logic              io_wready,
    output logic [ID_W-1:0]   io_bid,
    output logic [1:0]        io_bresp,
    output logic              io_bvalid,
    input  logic              io_bready,
    input  logic [ID_W-1:0]   io_arid,
    input  logic [31:0]       io_araddr,
    input  logic [7:0]        io_arlen,
    input  logic              io_arvalid,
    output logic              io_arready,
    output logic [ID_W-1:0]   io_rid,
    output logic [DATA_W-1:0] io_rdata,
    output logic [1:0]        io_rresp,
    output logic              io_rlast,
    output logic              io_rvalid,
    input  logic              io_rready,
    output logic [DATA_W-1:0] tx_data,
    output logic              tx_valid,
    input  logic              tx_ready,
    input  logic [DATA_W-1:0] rx_data,
    input  logic              rx_valid,
    output logic              rx_ready
);
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wstate_t;
    typedef enum logic [1:0] {R_IDLE, R_FETCH, R_SEND} rstate_t;

    wstate_t wstate, wstate_nxt;
    rstate_t rstate, rstate_nxt;

    logic [ID_W-1:0]   wid, rid_q;
    logic [7:0]        wlen, wcnt, rlen, rcnt;
    logic              wsel, rsel, werr, fwd;
    logic [DATA_W-1:0] rdata_q, stat;
    logic              aw_hs, w_hs, ar_hs, r_hs;
    logic              unused_addr;

    assign unused_addr = ^{io_awaddr, io_araddr};
    assign io_rresp    = 2'b00;
    assign aw_hs       = io_awvalid && io_awready;
    assign w_hs        = io_wvalid && io_wready;
    assign ar_hs       = io_arvalid && io_arready;
    assign r_hs        = io_rvalid && io_rready;
    assign fwd         = !wsel && io_wstrb;

    always_ff @(posedge clk) begin
        if (rst) begin
            wstate <= W_IDLE;
            rstate <= R_IDLE;
        end else begin
            wstate <= wstate_nxt;
            rstate <= rstate_nxt;
        end
    end

    // Every output is forced low while rst is high, regardless of the current state.
    always_comb begin
        wstate_nxt = wstate;
        io_awready = 1'b0;
        io_wready  = 1'b0;
        tx_valid   = 1'b0;
        tx_data    = '0;
        io_bvalid  = 1'b0;
        io_bid     = '0;
        io_bresp   = 2'b00;
        if (!rst) begin
            case (wstate)
                W_IDLE: begin
                    io_awready = 1'b1;
                    if (io_awvalid) wstate_nxt = W_DATA;
                end
                W_DATA: begin
                    tx_valid  = fwd && io_wvalid;
                    tx_data   = fwd ? io_wdata : '0;
                    io_wready = fwd ? tx_ready : 1'b1;
                    if (io_wvalid && io_wready && io_wlast) wstate_nxt = W_RESP;
                end
                W_RESP: begin
                    io_bvalid = 1'b1;
                    io_bid    = wid;
                    io_bresp  = werr ? 2'b10 : 2'b00;
                    if (io_bready) wstate_nxt = W_IDLE;
                end
                default: wstate_nxt = W_IDLE;
            endcase
        end
    end

    always_comb begin
        rstate_nxt = rstate;
        io_arready = 1'b0;
        rx_ready   = 1'b0;
        io_rvalid  = 1'b0;
        io_rdata   = '0;
        io_rid     = '0;
        io_rlast   = 1'b0;
        if (!rst) begin
            case (rstate)
                R_IDLE: begin
                    io_arready = 1'b1;
                    if (io_arvalid) rstate_nxt = R_FETCH;
                end
                R_FETCH: begin
                    if (rsel) begin
                        rstate_nxt = R_SEND;
                    end else begin
                        rx_ready = 1'b1;
                        if (rx_valid) rstate_nxt = R_SEND;
                    end
                end
                R_SEND: begin
                    io_rvalid = 1'b1;
                    io_rdata  = rdata_q;
                    io_rid    = rid_q;
                    io_rlast  = (rcnt == rlen);
                    if (io_rready) rstate_nxt = io_rlast ? R_IDLE : R_FETCH;
                end
                default: rstate_nxt = R_IDLE;
            endcase
        end
    end

    always_comb begin
        stat    = '0;
        stat[0] = rx_valid;
        stat[1] = tx_ready;
    end

    // A length error is any beat where wlast disagrees with "this is beat awlen".
    always_ff @(posedge clk) begin
        if (rst) begin
            wid  <= '0;
            wlen <= '0;
            wsel <= 1'b0;
            wcnt <= '0;
            werr <= 1'b0;
        end else if (aw_hs) begin
            wid  <= io_awid;
            wlen <= io_awlen;
            wsel <= io_awaddr[STAT_BIT];
            wcnt <= '0;
            werr <= 1'b0;
        end else if (w_hs) begin
            wcnt <= wcnt + 8'd1;
            if (io_wlast != (wcnt == wlen)) werr <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rid_q   <= '0;
            rlen    <= '0;
            rsel    <= 1'b0;
            rcnt    <= '0;
            rdata_q <= '0;
        end else begin
            if (ar_hs) begin
                rid_q <= io_arid;
                rlen  <= io_arlen;
                rsel  <= io_araddr[STAT_BIT];
                rcnt  <= '0;
            end
            if (rstate == R_FETCH) begin
                if (rsel)                      rdata_q <= stat;
                else if (rx_valid && rx_ready) rdata_q <= rx_data;
            end
            if (r_hs && !io_rlast) rcnt <= rcnt + 8'd1;
        end
    end
endmodule

// File: tb/tb_fcpu_io_axi_slave.sv
// Directed bench for fcpu_io_axi_slave: queued W/rx stimulus, scoreboard queues for
// tx bytes, B and R beats, all checked on the falling edge.
module tb_fcpu_io_axi_slave;
    localparam int ID_W = 4, DATA_W = 8;

    typedef struct { logic [7:0] data; logic strb; logic last; } w_t;
    typedef struct { logic [3:0] id; logic [1:0] resp; } b_t;
    typedef struct { logic [3:0] id; logic [7:0] data; logic last; } r_t;

    logic clk = 1'b0, rst = 1'b1;
    logic [ID_W-1:0] io_awid = '0, io_bid, io_arid = '0, io_rid;
    logic [31:0] io_awaddr = '0, io_araddr = '0;
    logic [7:0] io_awlen = '0, io_arlen = '0;
    logic io_awvalid = 0, io_awready, io_wstrb = 0, io_wlast = 0, io_wvalid = 0, io_wready;
    logic [DATA_W-1:0] io_wdata = '0, io_rdata, tx_data, rx_data = '0;
    logic [1:0] io_bresp, io_rresp;
    logic io_bvalid, io_bready = 0, io_arvalid = 0, io_arready, io_rlast, io_rvalid, io_rready = 0;
    logic tx_valid, tx_ready = 0, rx_valid = 0, rx_ready;

    fcpu_io_axi_slave #(.ID_W(ID_W), .DATA_W(DATA_W), .STAT_BIT(2)) dut (
        .clk(clk), .rst(rst),
        .io_awid(io_awid), .io_awaddr(io_awaddr), .io_awlen(io_awlen),
        .io_awvalid(io_awvalid), .io_awready(io_awready),
        .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_wlast(io_wlast),
        .io_wvalid(io_wvalid), .io_wready(io_wready),
        .io_bid(io_bid), .io_bresp(io_bresp), .io_bvalid(io_bvalid), .io_bready(io_bready),
        .io_arid(io_arid), .io_araddr(io_araddr), .io_arlen(io_arlen),
        .io_arvalid(io_arvalid), .io_arready(io_arready),
        .io_rid(io_rid), .io_rdata(io_rdata), .io_rresp(io_rresp), .io_rlast(io_rlast),
        .io_rvalid(io_rvalid), .io_rready(io_rready),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0, rx_pulses = 0, rx_rdy_cyc = 0, rx_gap = 0;
    w_t w_q[$];
    logic [7:0] rx_q[$];
    logic [7:0] exp_tx[$];
    b_t exp_b[$];
    r_t exp_r[$];
    logic aw_hs, w_hs, ar_hs, rx_hs;
    logic tx_hold = 0, b_hold = 0, r_hold = 0;
    logic [7:0] tx_prev;
    logic [5:0] b_prev;
    logic [12:0] r_prev;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_w"}, {io_awready, io_wready, io_bid, io_bresp, io_bvalid, tx_data, tx_valid}, 0);
        chk({tag, "_r"}, {io_arready, io_rid, io_rdata, io_rresp, io_rlast, io_rvalid, rx_ready}, 0);
    endtask

    // One clock: monitor/scoreboard on the falling edge, then drivers just after the rising edge.
    task automatic tick();
        w_t wb;
        b_t eb;
        r_t er;
        @(negedge clk);
        if (!rst) begin
            if (tx_hold) chk("tx_stable", {tx_valid, tx_data}, {1'b1, tx_prev});
            if (b_hold) chk("b_stable", {io_bvalid, io_bid, io_bresp}, {1'b1, b_prev});
            if (r_hold) chk("r_stable", {io_rvalid, io_rid, io_rdata, io_rlast}, {1'b1, r_prev});
            if (tx_valid && tx_ready) begin
                if (exp_tx.size() == 0) chk("tx_extra", tx_valid, 0);
                else chk("tx_data", tx_data, exp_tx.pop_front());
            end
            if (io_bvalid && io_bready) begin
                if (exp_b.size() == 0) chk("b_extra", io_bvalid, 0);
                else begin
                    eb = exp_b.pop_front();
                    chk("b_beat", {io_bid, io_bresp}, {eb.id, eb.resp});
                end
            end
            if (io_rvalid && io_rready) begin
                if (exp_r.size() == 0) chk("r_extra", io_rvalid, 0);
                else begin
                    er = exp_r.pop_front();
                    chk("r_beat", {io_rid, io_rdata, io_rlast, io_rresp}, {er.id, er.data, er.last, 2'b00});
                end
            end
            if (rx_valid && rx_ready) rx_pulses++;
            if (rx_ready) rx_rdy_cyc++;
            tx_hold = tx_valid && !tx_ready;
            tx_prev = tx_data;
            b_hold = io_bvalid && !io_bready;
            b_prev = {io_bid, io_bresp};
            r_hold = io_rvalid && !io_rready;
            r_prev = {io_rid, io_rdata, io_rlast};
        end else begin
            tx_hold = 0; b_hold = 0; r_hold = 0;
        end
        aw_hs = io_awvalid && io_awready;
        w_hs  = io_wvalid && io_wready;
        ar_hs = io_arvalid && io_arready;
        rx_hs = rx_valid && rx_ready;
        @(posedge clk);
        #1;
        if (aw_hs) io_awvalid = 0;
        if (ar_hs) io_arvalid = 0;
        if (w_hs) io_wvalid = 0;
        if (!io_wvalid && w_q.size() > 0) begin
            wb = w_q.pop_front();
            io_wdata = wb.data; io_wstrb = wb.strb; io_wlast = wb.last; io_wvalid = 1;
        end
        if (rx_hs) begin
            rx_valid = 0;
            rx_gap = 2;
        end else if (!rx_valid) begin
            if (rx_gap > 0) rx_gap--;
            else if (rx_q.size() > 0) begin
                rx_data = rx_q.pop_front();
                rx_valid = 1;
            end
        end
    endtask

    task automatic send_aw(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        io_awid = id; io_awaddr = addr; io_awlen = len; io_awvalid = 1;
    endtask

    task automatic send_ar(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len);
        io_arid = id; io_araddr = addr; io_arlen = len; io_arvalid = 1;
    endtask

    task automatic push_w(input logic [7:0] d, input logic strb, input logic last, input logic to_tx);
        w_t wb;
        wb.data = d; wb.strb = strb; wb.last = last;
        w_q.push_back(wb);
        if (strb && to_tx) exp_tx.push_back(d);
    endtask

    task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
        b_t eb;
        eb.id = id; eb.resp = resp;
        exp_b.push_back(eb);
    endtask

    task automatic push_r(input logic [3:0] id, input logic [7:0] d, input logic last);
        r_t er;
        er.id = id; er.data = d; er.last = last;
        exp_r.push_back(er);
    endtask

    task automatic wait_done(input int budget);
        int n = 0;
        while ((exp_tx.size() + exp_b.size() + exp_r.size() + w_q.size() > 0 || io_wvalid) && n < budget) begin
            tick();
            n++;
        end
        chk("pending", exp_tx.size() + exp_b.size() + exp_r.size(), 0);
    endtask

    initial begin
        int n;
        io_awvalid = 1;
        repeat (3) tick();
        chk_zero("reset");
        io_awvalid = 0;
        rst = 0;
        #1;
        chk("awready_idle", io_awready, 1);
        chk("arready_idle", io_arready, 1);

        // single write, tx held off for several cycles
        tx_ready = 0; io_bready = 1;
        send_aw(3, 0, 0);
        push_w(8'h41, 1, 1, 1);
        push_b(3, 2'b00);
        repeat (7) tick();
        chk("tx_wait", {tx_valid, tx_data}, {1'b1, 8'h41});
        tx_ready = 1;
        wait_done(20);

        // 4-beat read with gapped rx bytes
        io_rready = 1; rx_pulses = 0;
        send_ar(5, 0, 3);
        for (int i = 0; i < 4; i++) begin
            rx_q.push_back(8'h10 + 8'(i));
            push_r(5, 8'h10 + 8'(i), i == 3);
        end
        wait_done(100);
        chk("rx_pulses", rx_pulses, 4);

        // status reads: latency N+2, no rx consumption
        repeat (4) tick();
        tx_ready = 0; rx_valid = 1; rx_data = 8'hEE; rx_rdy_cyc = 0;
        push_r(6, 8'h01, 1);
        send_ar(6, 32'h4, 0);
        tick();
        chk("st_lat1", io_rvalid, 0);
        tick();
        chk("st_lat2", io_rvalid, 1);
        wait_done(10);
        chk("st_rx_ready", rx_rdy_cyc, 0);
        rx_valid = 0; tx_ready = 1;
        push_r(6, 8'h02, 1);
        send_ar(6, 32'h4, 0);
        wait_done(10);

        // length errors, dropped strobes, status-address write
        send_aw(2, 0, 1);
        push_w(8'h55, 1, 1, 1);
        push_b(2, 2'b10);
        wait_done(30);
        send_aw(7, 0, 2);
        push_w(8'h60, 1, 0, 1);
        push_w(8'hAA, 0, 0, 1);
        push_w(8'h61, 1, 1, 1);
        push_b(7, 2'b00);
        wait_done(30);
        send_aw(1, 32'h4, 0);
        push_w(8'h99, 1, 1, 0);
        push_b(1, 2'b00);
        wait_done(30);
        send_aw(8, 0, 0);
        push_w(8'h70, 1, 0, 1);
        push_w(8'h71, 1, 1, 1);
        push_b(8, 2'b10);
        wait_done(30);

        // concurrent write and read under B/R backpressure
        io_bready = 0; io_rready = 0;
        send_aw(9, 0, 1);
        send_ar(4, 0, 1);
        push_w(8'h80, 1, 0, 1);
        push_w(8'h81, 1, 1, 1);
        rx_q.push_back(8'h20);
        rx_q.push_back(8'h21);
        push_b(9, 2'b00);
        push_r(4, 8'h20, 0);
        push_r(4, 8'h21, 1);
        repeat (8) tick();
        chk("cc_bvalid", io_bvalid, 1);
        chk("cc_rvalid", {io_rvalid, io_rdata}, {1'b1, 8'h20});
        io_bready = 1; io_rready = 1;
        wait_done(50);

        // reset during the second beat of a 4-beat read
        send_ar(11, 0, 3);
        for (int i = 0; i < 4; i++) rx_q.push_back(8'h30 + 8'(i));
        push_r(11, 8'h30, 0);
        n = 0;
        while (exp_r.size() > 0 && n < 50) begin
            tick();
            n++;
        end
        chk("mid_first", exp_r.size(), 0);
        tick();
        rst = 1;
        #1;
        chk_zero("rst_now");
        tick();
        chk_zero("rst_next");
        rst = 0;
        rx_q.delete(); rx_valid = 0; rx_gap = 0;
        repeat (10) tick();
        rx_q.push_back(8'h44);
        push_r(12, 8'h44, 1);
        send_ar(12, 0, 0);
        wait_done(30);

        chk("final_empty", exp_tx.size() + exp_b.size() + exp_r.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end
endmodule
